// File: rtl/warp_lsu_pkg.sv
// Shared types for the warp-wide load-store unit: scheduler/warp states, LSU
// states and the latched transfer mode.
package warp_lsu_pkg;

  typedef enum logic [2:0] {
    WARP_IDLE    = 3'd0,
    WARP_FETCH   = 3'd1,
    WARP_DECODE  = 3'd2,
    WARP_REQUEST = 3'd3,
    WARP_WAIT    = 3'd4,
    WARP_EXECUTE = 3'd5,
    WARP_UPDATE  = 3'd6,
    WARP_DONE    = 3'd7
  } warp_state_t;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t LSU_IDLE       = 2'd0;
  localparam lsu_state_t LSU_REQUESTING = 2'd1;
  localparam lsu_state_t LSU_WAITING    = 2'd2;
  localparam lsu_state_t LSU_DONE       = 2'd3;

  typedef enum logic {
    LSU_MODE_READ  = 1'b0,
    LSU_MODE_WRITE = 1'b1
  } lsu_mode_t;

endpackage

// File: rtl/warp_lsu_if.sv
// Per-channel data-memory bus between the warp LSU (master) and the memory
// controller (slave).
interface warp_lsu_if #(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned ADDR_WIDTH   = 16
);
  logic [NUM_CHANNELS-1:0]            mem_read_valid;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_read_address;
  logic [NUM_CHANNELS-1:0]            mem_read_ready;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_read_data;
  logic [NUM_CHANNELS-1:0]            mem_write_valid;
  logic [NUM_CHANNELS*ADDR_WIDTH-1:0] mem_write_address;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] mem_write_data;
  logic [NUM_CHANNELS-1:0]            mem_write_ready;

  modport master (
    output mem_read_valid, mem_read_address,
    input  mem_read_ready, mem_read_data,
    output mem_write_valid, mem_write_address, mem_write_data,
    input  mem_write_ready
  );

  modport slave (
    input  mem_read_valid, mem_read_address,
    output mem_read_ready, mem_read_data,
    input  mem_write_valid, mem_write_address, mem_write_data,
    output mem_write_ready
  );
endinterface

// File: rtl/warp_lsu_channel.sv
// One memory channel of the warp LSU: tracks the pending lanes of its stripe
// and presents them lowest-first, one transfer at a time.
module lsu_channel
  import warp_lsu_pkg::*;
#(
  parameter int unsigned LANES      = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 16,
  localparam int unsigned LW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                enable,
  input  logic                                accept_i,
  input  logic                                launch_i,
  input  logic [LANES-1:0]                    mask_i,
  input  logic [LANES-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [LANES-1:0][DATA_WIDTH-1:0]    data_i,
  input  logic                                ready_i,
  output logic                                valid_o,
  output logic [ADDR_WIDTH-1:0]               addr_o,
  output logic [DATA_WIDTH-1:0]               data_o,
  output logic [LW-1:0]                       lane_o,
  output logic                                retire_o,
  output logic                                busy_o
);

  logic [LANES-1:0]      pending_q, pending_d, pend_left;
  logic                  valid_q, valid_d;
  logic [LW-1:0]         lane_q, lane_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;

  function automatic logic [LW-1:0] lowest(input logic [LANES-1:0] v);
    logic [LW-1:0] idx;
    idx = '0;
    for (int unsigned i = LANES; i > 0; i--) begin
      if (v[i-1]) idx = LW'(i - 1);
    end
    return idx;
  endfunction

  assign retire_o = enable && valid_q && ready_i;

  // Launch and retire share one path: both present the lowest lane still
  // pending after the current beat (if any), keeping valid high back-to-back.
  always_comb begin
    pend_left = pending_q;
    if (retire_o) pend_left[lane_q] = 1'b0;
    pending_d = pending_q;
    valid_d   = valid_q;
    lane_d    = lane_q;
    addr_d    = addr_q;
    data_d    = data_q;
    if (enable) begin
      if (accept_i) begin
        pending_d = mask_i;
        valid_d   = 1'b0;
      end else if (launch_i || retire_o) begin
        pending_d = pend_left;
        valid_d   = |pend_left;
        if (|pend_left) begin
          lane_d = lowest(pend_left);
          addr_d = addr_i[lane_d];
          data_d = data_i[lane_d];
        end
      end
    end
  end

  // Look-ahead busy lets the FSM reach DONE in the same cycle as the last beat.
  assign busy_o = |pending_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
      valid_q   <= 1'b0;
      lane_q    <= '0;
      addr_q    <= '0;
      data_q    <= '0;
    end else begin
      pending_q <= pending_d;
      valid_q   <= valid_d;
      lane_q    <= lane_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;
  assign lane_o  = lane_q;

endmodule

// File: rtl/warp_lsu.sv
// Warp-wide load-store unit: one FSM for the whole warp, lanes striped over
// NUM_CHANNELS independent memory channels.
module warp_lsu
  import warp_lsu_pkg::*;
#(
  parameter int unsigned THREADS_PER_WARP = 16,
  parameter int unsigned NUM_CHANNELS     = 4,
  parameter int unsigned DATA_WIDTH       = 32,
  parameter int unsigned ADDR_WIDTH       = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   enable,
  input  warp_state_t                            warp_state,
  input  logic [THREADS_PER_WARP-1:0]            thread_mask,
  input  logic                                   decoded_mem_read_enable,
  input  logic                                   decoded_mem_write_enable,
  input  logic [THREADS_PER_WARP*DATA_WIDTH-1:0] rs1,
  input  logic [THREADS_PER_WARP*DATA_WIDTH-1:0] rs2,
  input  logic [DATA_WIDTH-1:0]                  imm,
  warp_lsu_if.master                             mem,
  output lsu_state_t                             lsu_state,
  output logic [THREADS_PER_WARP*DATA_WIDTH-1:0] lsu_out
);

  localparam int unsigned LANES = THREADS_PER_WARP / NUM_CHANNELS;
  localparam int unsigned LW    = (LANES > 1) ? $clog2(LANES) : 1;

  lsu_state_t state_q, state_d;
  lsu_mode_t  mode_q, mode_d;
  logic       accept, launch, any_busy;

  logic [NUM_CHANNELS-1:0]                 ch_valid, ch_ready, ch_retire, ch_busy;
  logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0] ch_addr;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] ch_data;
  logic [NUM_CHANNELS-1:0][LW-1:0]         ch_lane;

  logic [THREADS_PER_WARP-1:0][DATA_WIDTH-1:0] lsu_out_q;

  assign accept = enable && (state_q == LSU_IDLE) && (warp_state == WARP_REQUEST)
               && (decoded_mem_read_enable || decoded_mem_write_enable);
  assign launch   = (state_q == LSU_REQUESTING);
  assign any_busy = |ch_busy;

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    if (enable) begin
      case (state_q)
        LSU_IDLE: begin
          if (accept) begin
            state_d = LSU_REQUESTING;
            // A read request takes precedence when both enables are set.
            mode_d  = decoded_mem_read_enable ? LSU_MODE_READ : LSU_MODE_WRITE;
          end
        end
        LSU_REQUESTING: state_d = any_busy ? LSU_WAITING : LSU_DONE;
        LSU_WAITING:    if (!any_busy) state_d = LSU_DONE;
        LSU_DONE:       if (warp_state == WARP_UPDATE) state_d = LSU_IDLE;
        default:        state_d = LSU_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= LSU_IDLE;
      mode_q  <= LSU_MODE_READ;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
    end
  end

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_ch
    logic [LANES-1:0]                 s_mask;
    logic [LANES-1:0][ADDR_WIDTH-1:0] s_addr;
    logic [LANES-1:0][DATA_WIDTH-1:0] s_data;

    // Stripe c holds lanes c, c+C, c+2C, ...; addresses wrap at 2^AW.
    always_comb begin
      s_mask = '0;
      s_addr = '0;
      s_data = '0;
      for (int unsigned j = 0; j < LANES; j++) begin
        s_mask[j] = thread_mask[c + NUM_CHANNELS*j];
        s_addr[j] = rs1[(c + NUM_CHANNELS*j)*DATA_WIDTH +: ADDR_WIDTH] + imm[ADDR_WIDTH-1:0];
        s_data[j] = rs2[(c + NUM_CHANNELS*j)*DATA_WIDTH +: DATA_WIDTH];
      end
    end

    assign ch_ready[c] = (mode_q == LSU_MODE_WRITE) ? mem.mem_write_ready[c]
                                                    : mem.mem_read_ready[c];

    lsu_channel #(
      .LANES      (LANES),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .accept_i (accept),
      .launch_i (launch),
      .mask_i   (s_mask),
      .addr_i   (s_addr),
      .data_i   (s_data),
      .ready_i  (ch_ready[c]),
      .valid_o  (ch_valid[c]),
      .addr_o   (ch_addr[c]),
      .data_o   (ch_data[c]),
      .lane_o   (ch_lane[c]),
      .retire_o (ch_retire[c]),
      .busy_o   (ch_busy[c])
    );
  end

  assign mem.mem_read_valid    = ch_valid & {NUM_CHANNELS{mode_q == LSU_MODE_READ}};
  assign mem.mem_write_valid   = ch_valid & {NUM_CHANNELS{mode_q == LSU_MODE_WRITE}};
  assign mem.mem_read_address  = ch_addr;
  assign mem.mem_write_address = ch_addr;
  assign mem.mem_write_data    = ch_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      lsu_out_q <= '0;
    end else if (mode_q == LSU_MODE_READ) begin
      for (int unsigned t = 0; t < THREADS_PER_WARP; t++) begin
        if (ch_retire[t % NUM_CHANNELS] && (ch_lane[t % NUM_CHANNELS] == LW'(t / NUM_CHANNELS)))
          lsu_out_q[t] <= mem.mem_read_data[(t % NUM_CHANNELS)*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign lsu_state = state_q;
  assign lsu_out   = lsu_out_q;

  // Operand bits above the address width never reach the memory side.
  logic unused_hi;
  always_comb begin
    unused_hi = ^imm[DATA_WIDTH-1:ADDR_WIDTH];
    for (int unsigned t = 0; t < THREADS_PER_WARP; t++)
      unused_hi = unused_hi ^ (^rs1[t*DATA_WIDTH + ADDR_WIDTH +: DATA_WIDTH - ADDR_WIDTH]);
  end

endmodule

// File: tb/tb_warp_lsu.sv
// Self-checking bench for warp_lsu: per-channel expected-transfer queues and a
// lane-result array model the warp-level load/store behaviour.
module tb_warp_lsu;
  import warp_lsu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, enable;
  warp_state_t warp_state;
  logic [15:0] thread_mask;
  logic        re, we;
  logic [511:0] rs1, rs2;
  logic [31:0] imm;
  lsu_state_t  lsu_state;
  logic [511:0] lsu_out;

  warp_lsu_if #(.NUM_CHANNELS(4), .DATA_WIDTH(32), .ADDR_WIDTH(16)) mem_if ();

  warp_lsu #(
    .THREADS_PER_WARP (16),
    .NUM_CHANNELS     (4),
    .DATA_WIDTH       (32),
    .ADDR_WIDTH       (16)
  ) dut (
    .clk                      (clk),
    .reset                    (reset),
    .enable                   (enable),
    .warp_state               (warp_state),
    .thread_mask              (thread_mask),
    .decoded_mem_read_enable  (re),
    .decoded_mem_write_enable (we),
    .rs1                      (rs1),
    .rs2                      (rs2),
    .imm                      (imm),
    .mem                      (mem_if),
    .lsu_state                (lsu_state),
    .lsu_out                  (lsu_out)
  );

  always #5 clk = ~clk;

  logic [31:0] rs1_a [16];
  logic [31:0] rs2_a [16];
  logic [31:0] exp_out [16];
  logic [15:0] q_addr [4][4];
  logic [31:0] q_data [4][4];
  int          q_lane [4][4];
  int          q_head [4];
  int          q_cnt  [4];
  logic [31:0] salt;
  int          checks, errors;
  int          last_done_k;
  logic [15:0] first_addr0;

  function automatic logic [31:0] rd_val(input logic [15:0] a);
    return ({16'h0, a} + 32'd1) ^ salt;
  endfunction

  task automatic randomize_operands();
    for (int t = 0; t < 16; t++) begin
      rs1_a[t] = $urandom;
      rs2_a[t] = $urandom;
    end
    imm = $urandom;
  endtask

  task automatic check_lsu_out(input string name);
    logic [511:0] e;
    for (int t = 0; t < 16; t++) e[t*32 +: 32] = exp_out[t];
    checks++;
    if (lsu_out !== e) begin
      errors++;
      $display("FAIL %s lsu_out got %h exp %h", name, lsu_out[127:0], e[127:0]);
    end
  endtask

  // Runs one warp request to completion and back to IDLE.
  task automatic run_op(input bit rd, input bit wr, input logic [15:0] mask,
                        input int ready_pct, input int stall_ch, input int stall_len,
                        input int hold_start, input int hold_len, input int done_wait,
                        input string name);
    int rem [4];
    bit done, hold, empty;
    int k, t;
    lsu_state_t exp_state;
    logic [3:0] exp_v, obs_v, oth_v, r;
    logic [127:0] rdata;
    logic [15:0] a, obs_a;

    for (int c = 0; c < 4; c++) begin
      q_head[c] = 0;
      q_cnt[c]  = 0;
      for (int j = 0; j < 4; j++) begin
        t = c + 4*j;
        if (mask[t]) begin
          q_addr[c][q_cnt[c]] = 16'(rs1_a[t] + imm);
          q_data[c][q_cnt[c]] = rs2_a[t];
          q_lane[c][q_cnt[c]] = t;
          q_cnt[c]++;
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      rs1[i*32 +: 32] = rs1_a[i];
      rs2[i*32 +: 32] = rs2_a[i];
    end

    @(negedge clk);
    warp_state  = WARP_REQUEST;
    re          = rd;
    we          = wr;
    thread_mask = mask;
    @(posedge clk);

    done = 1'b0;
    k = 0;
    last_done_k = 0;
    first_addr0 = '0;
    while (!done && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) begin
        warp_state  = WARP_WAIT;
        re          = 1'b0;
        we          = 1'b0;
        thread_mask = 16'($urandom);
      end
      hold   = (k >= hold_start) && (k < hold_start + hold_len);
      enable = !hold;
      empty  = 1'b1;
      for (int c = 0; c < 4; c++) begin
        rem[c]   = q_cnt[c] - q_head[c];
        exp_v[c] = (k >= 2) && (rem[c] > 0);
        if (rem[c] > 0) empty = 1'b0;
      end
      exp_state = (k == 1) ? LSU_REQUESTING : (empty ? LSU_DONE : LSU_WAITING);
      if (lsu_state == LSU_DONE && last_done_k == 0) last_done_k = k;
      if (k == 2) first_addr0 = mem_if.mem_read_address[15:0];

      checks++;
      if (lsu_state !== exp_state) begin
        errors++;
        $display("FAIL %s state k=%0d got %0d exp %0d", name, k, lsu_state, exp_state);
      end
      obs_v = rd ? mem_if.mem_read_valid : mem_if.mem_write_valid;
      oth_v = rd ? mem_if.mem_write_valid : mem_if.mem_read_valid;
      checks++;
      if (obs_v !== exp_v) begin
        errors++;
        $display("FAIL %s valid k=%0d got %b exp %b", name, k, obs_v, exp_v);
      end
      checks++;
      if (oth_v !== 4'b0000) begin
        errors++;
        $display("FAIL %s other_dir_valid k=%0d got %b exp 0000", name, k, oth_v);
      end

      r = '0;
      rdata = '0;
      for (int c = 0; c < 4; c++) begin
        if (exp_v[c]) begin
          a = q_addr[c][q_head[c]];
          obs_a = rd ? mem_if.mem_read_address[c*16 +: 16] : mem_if.mem_write_address[c*16 +: 16];
          checks++;
          if (obs_a !== a) begin
            errors++;
            $display("FAIL %s addr ch%0d k=%0d got %h exp %h", name, c, k, obs_a, a);
          end
          if (!rd) begin
            checks++;
            if (mem_if.mem_write_data[c*32 +: 32] !== q_data[c][q_head[c]]) begin
              errors++;
              $display("FAIL %s wdata ch%0d k=%0d got %h exp %h", name, c, k,
                       mem_if.mem_write_data[c*32 +: 32], q_data[c][q_head[c]]);
            end
          end
          if (c == stall_ch && k < 2 + stall_len) r[c] = 1'b0;
          else if (hold) r[c] = 1'b1;
          else r[c] = ($urandom_range(99) < ready_pct);
          rdata[c*32 +: 32] = rd_val(a);
          if (r[c] && !hold) begin
            if (rd) exp_out[q_lane[c][q_head[c]]] = rd_val(a);
            q_head[c]++;
          end
        end
      end
      mem_if.mem_read_ready  = rd ? r : 4'b0000;
      mem_if.mem_write_ready = rd ? 4'b0000 : r;
      mem_if.mem_read_data   = rdata;
      if (exp_state == LSU_DONE) done = 1'b1;
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout got %0d cycles exp completion", name, k);
    end
    enable = 1'b1;
    mem_if.mem_read_ready  = '0;
    mem_if.mem_write_ready = '0;
    check_lsu_out(name);

    for (int i = 0; i < done_wait; i++) begin
      @(negedge clk);
      checks++;
      if (lsu_state !== LSU_DONE) begin
        errors++;
        $display("FAIL %s done_hold got %0d exp %0d", name, lsu_state, LSU_DONE);
      end
      warp_state = (i % 2 == 1) ? WARP_EXECUTE : WARP_WAIT;
    end
    @(negedge clk);
    checks++;
    if (lsu_state !== LSU_DONE) begin
      errors++;
      $display("FAIL %s done_before_update got %0d exp %0d", name, lsu_state, LSU_DONE);
    end
    warp_state = WARP_UPDATE;
    @(negedge clk);
    checks++;
    if (lsu_state !== LSU_IDLE) begin
      errors++;
      $display("FAIL %s idle_after_update got %0d exp %0d", name, lsu_state, LSU_IDLE);
    end
    warp_state = WARP_IDLE;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 16; t++) exp_out[t] = '0;
    checks++;
    if (lsu_state !== LSU_IDLE) begin
      errors++;
      $display("FAIL reset_state got %0d exp %0d", lsu_state, LSU_IDLE);
    end
    checks++;
    if ({mem_if.mem_read_valid, mem_if.mem_write_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_valid got %b exp 00000000", {mem_if.mem_read_valid, mem_if.mem_write_valid});
    end
    checks++;
    if ({mem_if.mem_read_address, mem_if.mem_write_address} !== 128'h0) begin
      errors++;
      $display("FAIL reset_addr got %h exp 0", {mem_if.mem_read_address, mem_if.mem_write_address});
    end
    checks++;
    if (mem_if.mem_write_data !== 128'h0) begin
      errors++;
      $display("FAIL reset_wdata got %h exp 0", mem_if.mem_write_data);
    end
    check_lsu_out("reset");
  endtask

  task automatic test_full_read();
    for (int t = 0; t < 16; t++) begin
      rs1_a[t] = 32'(t * 4);
      rs2_a[t] = $urandom;
    end
    imm  = 32'h100;
    salt = '0;
    run_op(1'b1, 1'b0, 16'hFFFF, 100, -1, 0, 0, 0, 0, "full_read");
    checks++;
    if (last_done_k !== 6) begin
      errors++;
      $display("FAIL full_read_latency got %0d exp 6", last_done_k);
    end
    checks++;
    if (lsu_out[5*32 +: 32] !== 32'h115) begin
      errors++;
      $display("FAIL full_read_lane5 got %h exp 00000115", lsu_out[5*32 +: 32]);
    end
  endtask

  task automatic test_write_stall();
    for (int t = 0; t < 16; t++) begin
      rs1_a[t] = 32'h00A0 + 32'(t);
      rs2_a[t] = 32'h00A0 + 32'(t);
    end
    imm = '0;
    run_op(1'b0, 1'b1, 16'h0005, 100, 1, 3, 0, 0, 0, "write_stall");
  endtask

  task automatic test_both_enabled();
    randomize_operands();
    salt = $urandom;
    run_op(1'b1, 1'b1, 16'($urandom) | 16'h0101, 70, -1, 0, 0, 0, 0, "both_enabled");
  endtask

  task automatic test_zero_mask();
    randomize_operands();
    run_op(1'b0, 1'b1, 16'h0000, 100, -1, 0, 0, 0, 3, "zero_mask");
  endtask

  task automatic test_addr_wrap();
    randomize_operands();
    rs1_a[0] = 32'h0000FFFF;
    imm      = 32'd2;
    salt     = '0;
    run_op(1'b1, 1'b0, 16'h0001, 100, -1, 0, 0, 0, 0, "addr_wrap");
    checks++;
    if (first_addr0 !== 16'h0001) begin
      errors++;
      $display("FAIL addr_wrap_value got %h exp 0001", first_addr0);
    end
  endtask

  task automatic test_no_mode();
    @(negedge clk);
    warp_state  = WARP_REQUEST;
    re          = 1'b0;
    we          = 1'b0;
    thread_mask = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (lsu_state !== LSU_IDLE || mem_if.mem_read_valid !== 4'b0 || mem_if.mem_write_valid !== 4'b0) begin
        errors++;
        $display("FAIL no_mode got state %0d valid %b%b exp %0d 00000000", lsu_state,
                 mem_if.mem_read_valid, mem_if.mem_write_valid, LSU_IDLE);
      end
    end
    warp_state = WARP_IDLE;
  endtask

  task automatic test_enable_hold();
    randomize_operands();
    salt = $urandom;
    run_op(1'b1, 1'b0, 16'hFFFF, 100, -1, 0, 3, 3, 0, "enable_hold");
  endtask

  task automatic test_back_to_back();
    bit rd, wr;
    for (int i = 0; i < 6; i++) begin
      randomize_operands();
      salt = $urandom;
      rd = 1'($urandom);
      wr = rd ? 1'($urandom) : 1'b1;
      run_op(rd, wr, 16'($urandom), 50, -1, 0, 0, 0, 0, "back_to_back");
    end
  endtask

  task automatic test_reset_mid();
    randomize_operands();
    for (int i = 0; i < 16; i++) begin
      rs1[i*32 +: 32] = rs1_a[i];
      rs2[i*32 +: 32] = rs2_a[i];
    end
    @(negedge clk);
    warp_state  = WARP_REQUEST;
    re          = 1'b1;
    we          = 1'b0;
    thread_mask = 16'hFFFF;
    mem_if.mem_read_ready = '0;
    @(negedge clk);
    warp_state = WARP_WAIT;
    re         = 1'b0;
    @(negedge clk);
    checks++;
    if (mem_if.mem_read_valid !== 4'hF || lsu_state !== LSU_WAITING) begin
      errors++;
      $display("FAIL reset_mid_pre got valid %b state %0d exp 1111 %0d",
               mem_if.mem_read_valid, lsu_state, LSU_WAITING);
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int t = 0; t < 16; t++) exp_out[t] = '0;
    checks++;
    if ({mem_if.mem_read_valid, mem_if.mem_write_valid} !== 8'h00) begin
      errors++;
      $display("FAIL reset_mid_valid got %b exp 00000000", {mem_if.mem_read_valid, mem_if.mem_write_valid});
    end
    checks++;
    if (lsu_state !== LSU_IDLE) begin
      errors++;
      $display("FAIL reset_mid_state got %0d exp %0d", lsu_state, LSU_IDLE);
    end
    check_lsu_out("reset_mid");
    warp_state = WARP_IDLE;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    salt   = '0;
    reset  = 1'b1;
    enable = 1'b1;
    warp_state  = WARP_IDLE;
    thread_mask = '0;
    re = 1'b0;
    we = 1'b0;
    rs1 = '0;
    rs2 = '0;
    imm = '0;
    mem_if.mem_read_ready  = '0;
    mem_if.mem_write_ready = '0;
    mem_if.mem_read_data   = '0;

    test_reset();
    test_full_read();
    test_write_stall();
    test_both_enabled();
    test_zero_mask();
    test_addr_wrap();
    test_no_mode();
    test_enable_hold();
    test_back_to_back();
    test_reset_mid();
    test_full_read();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/warp_lsu.md
# warp_lsu

Parametrised warp-wide load-store unit: one instance serves all threads of a warp instead of one LSU per thread. It executes LDR/STR for every active lane, spreads lane requests over `NUM_CHANNELS` independent memory channels, and reports a single warp-level `lsu_state`. It sits between the warp scheduler/register file and the data-memory controller, replacing the per-thread LSU array.

## Interface
- `THREADS_PER_WARP`, 16: lanes per warp (T)
- `NUM_CHANNELS`, 4: memory channels (C); T must be a multiple of C
- `DATA_WIDTH`, 32: data/register width (DW)
- `ADDR_WIDTH`, 16: data-memory address width (AW)

- `clk`  in  1  clock
- `reset`  in  1  reset, synchronous, active-high
- `enable`  in  1  block enable; when low, all state holds
- `warp_state`  in  warp_state_t  scheduler state of the owning warp
- `thread_mask`  in  T  active lanes, sampled on request acceptance
- `decoded_mem_read_enable`  in  1  LDR
- `decoded_mem_write_enable`  in  1  STR
- `rs1`  in  T*DW  per-lane base
- `rs2`  in  T*DW  per-lane store data
- `imm`  in  DW  shared offset
- `mem_read_valid`  out  C  per-channel read request
- `mem_read_address`  out  C*AW
- `mem_read_ready`  in  C
- `mem_read_data`  in  C*DW
- `mem_write_valid`  out  C
- `mem_write_address`  out  C*AW
- `mem_write_data`  out  C*DW
- `mem_write_ready`  in  C
- `lsu_state`  out  lsu_state_t  warp-level state
- `lsu_out`  out  T*DW  per-lane load result

## Operation
- Lane address = (rs1[t] + imm) mod 2^AW; lane t is bound to channel t mod C, so stripe order is t = c, c+C, c+2C, ...
- Mode: read when `decoded_mem_read_enable`; write when only `decoded_mem_write_enable`. If both are set, read wins and the write is ignored. If neither is set, the FSM holds.
- FSM:
  - LSU_IDLE → LSU_REQUESTING when `warp_state==WARP_REQUEST` and a mode is set. On this transition, latch `pending = thread_mask` and the mode.
  - LSU_REQUESTING → LSU_WAITING. Each channel whose stripe has pending lanes loads its lowest pending lane and asserts valid.
  - LSU_WAITING: on valid&&ready for channel c, clear that lane's pending bit. For reads, write `mem_read_data[c]` to `lsu_out[t]`. The channel then presents its next pending lane the next cycle with valid held high; otherwise it drops valid. When `pending==0` and all valid are low → LSU_DONE.
  - LSU_DONE → LSU_IDLE when `warp_state==WARP_UPDATE`.
- A zero `thread_mask` goes REQUESTING → DONE with no memory traffic.
- Inactive lanes keep their previous `lsu_out`.
- Address, data and mode are latched per transfer. Changes to `rs1`/`rs2`/`imm` after a lane is loaded do not affect that lane.

## Timing
- Reset values: `lsu_state`=LSU_IDLE; all valid=0; all addresses, write data and `lsu_out`=0; `pending`=0.
- REQUEST seen at cycle n → LSU_REQUESTING at n+1 → first valid at n+2.
- Ready is meaningful only while valid is high. Valid, address and data stay stable until ready.
- Back-to-back transfers on one channel: one beat per cycle when ready is held high.
- Minimum latency with all-ready memory and full mask: 2 + T/C cycles from REQUEST to LSU_DONE.
- Channels are independent. Simultaneous ready on several channels retires all of them in the same cycle.
- Reset mid-operation: all valid drop next cycle. Outstanding transfers are abandoned and the memory side must discard them.
- With `enable` low: no state or output changes, and ready is ignored.

## Structure
- `warp_state_t` and `lsu_state_t` come from the shared package in common.svh. Add `LSU_MODE_READ`/`LSU_MODE_WRITE` to it.
- Sub-module `lsu_channel`: one per channel (generate loop). It owns the stripe pending bits, the priority pick, and the valid/address/data registers, and exports `busy` and retire strobes.
- Top level: the FSM, the `lsu_out` register array and the address adders.

## Test plan
- Read, mask=0xFFFF, T=16, C=4, rs1[t]=t*4, imm=0x100, memory always ready returning addr+1 → DONE at cycle n+6; `lsu_out[t]`=0x100+4t+1.
- Write, mask=0x0005, rs2[t]=0xA0+t, channel 1 ready stalled 3 cycles → only channels 0 and 2 transfer (addr/data 0xA0, 0xA2); DONE with no channel-1 valid ever asserted.
- Both read and write enabled → only read valids toggle; all write_valid stay 0.
- mask=0 → LSU_REQUESTING then LSU_DONE; no valid; return to IDLE on WARP_UPDATE only.
- Address wrap: rs1=0xFFFF, imm=2, AW=16 → address 0x0001.
- Reset asserted in LSU_WAITING with valid high → next cycle all valid 0, LSU_IDLE, `lsu_out`=0.
